// File: rtl/display_share_arbiter_pkg.sv
// Shared types and helpers for the display-sharing arbiter: FSM encoding,
// blank-segment constant and the round-robin pick function.
package display_share_arbiter_pkg;

  localparam int IDX_W   = 3;
  localparam int MAX_REQ = 8;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t SHOW = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam logic [6:0] HEX_BLANK = 7'h7F;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit of req at or after ptr, wrapping modulo nreq.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [IDX_W-1:0]   ptr,
                                    input int                 nreq);
    pick_t p;
    int    j;
    p = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < nreq) begin
        j = (int'(ptr) + k) % nreq;
        if (!p.vld && req[j[IDX_W-1:0]]) begin
          p.vld = 1'b1;
          p.idx = j[IDX_W-1:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/display_share_arbiter_hex7seg.sv
// 4-bit value to active-low seven-segment pattern, bit0=a .. bit6=g, digits 0-F.
module display_share_arbiter_hex7seg
  import display_share_arbiter_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_BLANK;
    case (value)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = HEX_BLANK;
    endcase
  end

endmodule

// File: rtl/display_share_arbiter.sv
// Round-robin owner of HEX0/LEDR: each winner's nibble is snapshotted and shown
// for HOLD_CYCLES clocks, then a one-cycle ack closes the slot.
module display_share_arbiter
  import display_share_arbiter_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic              CLOCK_50,
  input  logic              Resetn,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] data,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   ack,
  output logic [6:0]        HEX0,
  output logic [9:0]        LEDR
);

  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NREQ - 1);
  localparam logic [MAX_REQ-1:0] ONE      = MAX_REQ'(1);

  state_t                 state;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       win;
  logic [CNT_W-1:0]       cnt;
  logic [3:0]             snap;
  logic [6:0]             seg;
  logic [MAX_REQ-1:0]     req_pad;
  logic [4*MAX_REQ-1:0]   data_pad;
  pick_t                  pick;

  assign req_pad  = MAX_REQ'(req);
  assign data_pad = (4*MAX_REQ)'(data);
  assign pick     = rr_pick(req_pad, ptr, NREQ);

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      grant <= '0;
      ack   <= '0;
      ptr   <= '0;
      win   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick.vld) begin
            state <= SHOW;
            win   <= pick.idx;
            grant <= NREQ'(ONE << pick.idx);
            cnt   <= CNT_LOAD;
          end
        end
        SHOW: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          // Withdrawal wins over completion when both happen on the same edge.
          if (!req_pad[win]) begin
            state <= DONE;
            grant <= '0;
          end else if (cnt == '0) begin
            state <= DONE;
            grant <= '0;
            ack   <= NREQ'(ONE << win);
          end
        end
        DONE: begin
          state <= IDLE;
          ack   <= '0;
          ptr   <= (win == LAST_IDX) ? '0 : win + IDX_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Snapshot is data only; it is qualified by state, so it needs no reset.
  always_ff @(posedge CLOCK_50) begin
    if (state == IDLE && pick.vld) snap <= data_pad[{pick.idx, 2'b00} +: 4];
  end

  display_share_arbiter_hex7seg u_hex7seg (
    .value (snap),
    .seg   (seg)
  );

  assign HEX0 = (state == SHOW) ? seg : HEX_BLANK;
  assign LEDR = {state != IDLE, 9'(grant)};

endmodule

// File: tb/tb_display_share_arbiter.sv
// Bench for display_share_arbiter (NREQ=4, HOLD_CYCLES=4): slot-level reference
// model compared every cycle, plus directed scenarios with literal expectations.
module tb_display_share_arbiter;

  localparam int NREQ  = 4;
  localparam int HOLD  = 4;
  localparam int CNT_W = 26;

  logic        clk    = 1'b0;
  logic        Resetn = 1'b0;
  logic [3:0]  req    = '0;
  logic [15:0] data   = '0;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic [6:0]  HEX0;
  logic [9:0]  LEDR;

  display_share_arbiter #(
    .NREQ        (NREQ),
    .HOLD_CYCLES (HOLD),
    .CNT_W       (CNT_W)
  ) dut (
    .CLOCK_50 (clk),
    .Resetn   (Resetn),
    .req      (req),
    .data     (data),
    .grant    (grant),
    .ack      (ack),
    .HEX0     (HEX0),
    .LEDR     (LEDR)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Slot-level model: who owns the display, how many display cycles remain,
  // whether we are in the one blank cycle after a slot, and whose ack is showing.
  int         m_owner = -1;
  int         m_left  = 0;
  int         m_ack   = -1;
  int         m_ptr   = 0;
  int         m_last  = 0;
  int         m_w     = -1;
  bit         m_after = 1'b0;
  logic [3:0] m_val   = '0;

  function automatic int rr_next(input logic [3:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  initial forever begin
    @(posedge clk or negedge Resetn);
    if (!Resetn) begin
      m_owner = -1; m_left = 0; m_ack = -1; m_ptr = 0; m_after = 1'b0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_after = 1'b1; m_ack = -1;
      end else if (m_left == 1) begin
        m_last = m_owner; m_ack = m_owner; m_owner = -1; m_after = 1'b1;
      end else begin
        m_left = m_left - 1;
      end
    end else if (m_after) begin
      m_after = 1'b0; m_ack = -1; m_ptr = (m_last + 1) % NREQ;
    end else begin
      m_w = rr_next(req, m_ptr);
      if (m_w >= 0) begin
        m_owner = m_w; m_left = HOLD; m_val = data[4*m_w +: 4];
      end
    end
  end

  logic [3:0] e_grant, e_ack;
  logic [6:0] e_hex;
  logic [9:0] e_led;

  initial forever begin
    @(negedge clk);
    e_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'h0;
    e_ack   = (m_ack >= 0) ? 4'(1 << m_ack) : 4'h0;
    e_hex   = (m_owner >= 0) ? seg_tab[m_val] : 7'h7F;
    e_led   = {(m_owner >= 0) || m_after, 5'b0, e_grant};
    chk("cyc_grant", 32'(grant), 32'(e_grant));
    chk("cyc_ack",   32'(ack),   32'(e_ack));
    chk("cyc_hex0",  32'(HEX0),  32'(e_hex));
    chk("cyc_ledr",  32'(LEDR),  32'(e_led));
  end

  int g_idx[$], g_len[$], g_start[$], g_end[$], g_hex[$], g_ackv[$], g_ackc[$], g_busy[$];

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int oh_idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic clr();
    g_idx.delete(); g_len.delete(); g_start.delete(); g_end.delete();
    g_hex.delete(); g_ackv.delete(); g_ackc.delete(); g_busy.delete();
  endtask

  // Requesters drop their req on the cycle their ack is visible.
  task automatic serve(input int budget, input string tag);
    logic [3:0] prev;
    int len, cyc;
    prev = grant; len = 0; cyc = 0;
    while ((req != 0 || LEDR[9]) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (grant != 0 && prev == 0) begin
        g_idx.push_back(oh_idx(grant)); g_start.push_back(cyc); g_hex.push_back(int'(HEX0)); len = 0;
      end
      if (grant != 0) len++;
      if (grant == 0 && prev != 0) begin
        g_len.push_back(len); g_end.push_back(cyc);
      end
      if (ack != 0) begin
        g_ackv.push_back(int'(ack)); g_ackc.push_back(cyc); g_busy.push_back(int'(LEDR[9]));
        req = req & ~ack;
      end
      prev = grant;
    end
    chk({tag, "_in_budget"}, 32'(cyc < budget), 32'd1);
  endtask

  task automatic wait_ack(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (ack != 0) found = 1'b1;
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    Resetn = 1'b0;
    req    = '0;
    repeat (2) @(negedge clk);
    Resetn = 1'b1;
  endtask

  bit found;

  initial begin
    // Reset, then idle with no requests.
    repeat (3) @(negedge clk);
    Resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t1_hex_blank", 32'(HEX0), 32'h7F);
      chk("t1_outs_zero", {18'd0, grant, ack, LEDR}, 32'd0);
    end

    // Single requester 1 showing 5.
    clr();
    req = 4'b0010; data = 16'h0050;
    serve(40, "t2");
    chk("t2_slots",  32'(g_idx.size()), 32'd1);
    chk("t2_owner",  32'(qget(g_idx, 0)), 32'd1);
    chk("t2_len",    32'(qget(g_len, 0)), 32'd4);
    chk("t2_hex",    32'(qget(g_hex, 0)), 32'h12);
    chk("t2_ackval", 32'(qget(g_ackv, 0)), 32'h2);
    chk("t2_ack1cy", 32'(g_ackv.size()), 32'd1);
    chk("t2_ack_at_fall", 32'(qget(g_ackc, 0)), 32'(qget(g_end, 0)));
    chk("t2_busy_done", 32'(qget(g_busy, 0)), 32'd1);

    // All four requesting from ptr=0.
    reset_dut();
    clr();
    req = 4'b1111; data = 16'h9876;
    serve(100, "t3");
    chk("t3_slots", 32'(g_idx.size()), 32'd4);
    chk("t3_acks",  32'(g_ackv.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_order%0d", i), 32'(qget(g_idx, i)), 32'(i));
      chk($sformatf("t3_len%0d", i),   32'(qget(g_len, i)), 32'd4);
    end
    for (int i = 0; i < 3; i++)
      chk($sformatf("t3_gap%0d", i), 32'(qget(g_start, i + 1) - qget(g_end, i)), 32'd2);

    // Data changes mid-slot are ignored; the next slot shows the new value.
    req = 4'b0001; data = 16'h0003;
    @(negedge clk);
    chk("t4_grant", 32'(grant), 32'h1);
    chk("t4_hex3",  32'(HEX0), 32'h30);
    data = 16'h0008;
    repeat (2) @(negedge clk);
    chk("t4_hex_held", 32'(HEX0), 32'h30);
    wait_ack(20, found);
    chk("t4_ack_seen", 32'(found), 32'd1);
    req = '0;
    repeat (2) @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    chk("t4_hex8", 32'(HEX0), 32'h00);
    wait_ack(20, found);
    chk("t4_ack2_seen", 32'(found), 32'd1);
    req = '0;
    repeat (2) @(negedge clk);

    // Requester 2 withdraws in its second SHOW cycle; ptr moves to 3.
    req = 4'b0100; data = 16'h0700;
    @(negedge clk);
    chk("t5_grant2", 32'(grant), 32'h4);
    @(negedge clk);
    req = 4'b1001;
    @(negedge clk);
    chk("t5_grant_off", 32'(grant), 32'h0);
    chk("t5_no_ack",    32'(ack), 32'h0);
    chk("t5_busy",      32'(LEDR[9]), 32'd1);
    @(negedge clk);
    chk("t5_no_ack_idle", 32'(ack), 32'h0);
    @(negedge clk);
    chk("t5_req3_wins", 32'(grant), 32'h8);
    wait_ack(20, found);
    chk("t5_ack3", 32'(ack), 32'h8);
    req = req & ~ack;
    clr();
    serve(40, "t5");
    chk("t5_then0", 32'(qget(g_idx, 0)), 32'd0);

    // Asynchronous reset in the middle of a slot.
    req = 4'b0100; data = 16'h0A00;
    @(negedge clk);
    chk("t6_grant2", 32'(grant), 32'h4);
    @(negedge clk);
    #2 Resetn = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(grant), 32'h0);
    chk("t6_rst_ack",   32'(ack), 32'h0);
    chk("t6_rst_hex",   32'(HEX0), 32'h7F);
    chk("t6_rst_ledr",  32'(LEDR), 32'h0);
    req = 4'b0011;
    @(negedge clk);
    @(negedge clk);
    Resetn = 1'b1;
    @(negedge clk);
    chk("t6_ptr0_grant", 32'(grant), 32'h1);
    chk("t6_ptr0_hex",   32'(HEX0), 32'h40);
    clr();
    serve(60, "t6");
    chk("t6_acks", 32'(g_ackv.size()), 32'd2);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
